// File: rtl/dsp_sample_scheduler_if.sv
// Bus bundle between the ADC front-end requesters and dsp_sample_scheduler.
// master: the requester/stimulus side; slave: the scheduler itself.
interface dsp_sample_scheduler_if #(
  parameter int width     = 12,
  parameter int channels  = 4,
  parameter int div_width = 8
);
  localparam int chan_w = $clog2(channels);

  logic                       enable;
  logic [div_width-1:0]       div;
  logic [channels-1:0]        req;
  logic [channels*width-1:0]  data_in;
  logic [channels-1:0]        ack;
  logic                       sampl_freq;
  logic signed [width-1:0]    data_out;
  logic [chan_w-1:0]          chan_out;
  logic [15:0]                idle_slots;

  modport master (
    output enable, div, req, data_in,
    input  ack, sampl_freq, data_out, chan_out, idle_slots
  );

  modport slave (
    input  enable, div, req, data_in,
    output ack, sampl_freq, data_out, chan_out, idle_slots
  );
endinterface

// File: rtl/dsp_sample_scheduler.sv
// Time-multiplexes one DC_Blocker pipeline across `channels` requesters using a
// programmable slot divider and a round-robin arbiter. Optional macro: SCHED_STATS_EN.
module dsp_sample_scheduler #(
  parameter int width     = 12,
  parameter int channels  = 4,
  parameter int div_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  dsp_sample_scheduler_if.slave  bus
);
  localparam int chan_w = $clog2(channels);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

  localparam logic [chan_w:0]   chan_lim  = (chan_w+1)'(channels);
  localparam logic [chan_w-1:0] chan_last = chan_w'(channels - 1);

  logic [0:0]              state_reg, state_next;
  logic [div_width-1:0]    cnt_reg, cnt_next;
  logic [div_width-1:0]    div_eff;
  logic                    slot;

  logic [chan_w-1:0]       ptr_reg, ptr_next;
  logic [2*channels-1:0]   req_dbl, req_shift;
  logic [channels-1:0]     req_rot;
  logic [chan_w:0]         grant_off, grant_sum;
  logic [chan_w-1:0]       grant_idx;
  logic                    grant_found;
  logic                    grant;

  logic [channels-1:0]     ack_reg, ack_next;
  logic                    sampl_freq_reg;
  logic signed [width-1:0] data_out_reg;
  logic [chan_w-1:0]       chan_out_reg;

  logic signed [width-1:0] data_arr [channels];

  generate
    for (genvar gi = 0; gi < channels; gi++) begin : g_unpack
      assign data_arr[gi] = bus.data_in[gi*width +: width];
    end
  endgenerate

  // div=0 behaves as div=1 so the slot period never collapses to a single cycle.
  always_comb begin
    div_eff = (bus.div == '0) ? div_width'(1) : bus.div;
    slot    = (state_reg == STATE_RUN) && (cnt_reg >= div_eff);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      STATE_IDLE: begin
        cnt_next = '0;
        if (bus.enable) begin
          state_next = STATE_RUN;
        end
      end
      STATE_RUN: begin
        cnt_next = slot ? '0 : cnt_reg + 1'b1;
        if (!bus.enable) begin
          state_next = STATE_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = STATE_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= STATE_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Rotate requests so bit 0 is the channel at ptr; lowest set bit wins.
  always_comb begin
    req_dbl     = {bus.req, bus.req};
    req_shift   = req_dbl >> ptr_reg;
    req_rot     = req_shift[channels-1:0];
    grant_found = 1'b0;
    grant_off   = '0;
    for (int i = channels - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_found = 1'b1;
        grant_off   = (chan_w+1)'(i);
      end
    end
    grant_sum = {1'b0, ptr_reg} + grant_off;
    if (grant_sum >= chan_lim) begin
      grant_sum = grant_sum - chan_lim;
    end
    grant_idx = grant_sum[chan_w-1:0];
    grant     = slot && grant_found;
    ptr_next  = ptr_reg;
    if (grant) begin
      ptr_next = (grant_idx == chan_last) ? '0 : grant_idx + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < channels; gi++) begin : g_ack
      assign ack_next[gi] = grant && (grant_idx == chan_w'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg        <= '0;
      ack_reg        <= '0;
      sampl_freq_reg <= 1'b0;
      data_out_reg   <= '0;
      chan_out_reg   <= '0;
    end else begin
      ptr_reg        <= ptr_next;
      ack_reg        <= ack_next;
      sampl_freq_reg <= grant;
      if (grant) begin
        data_out_reg <= data_arr[grant_idx];
        chan_out_reg <= grant_idx;
      end
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.sampl_freq = sampl_freq_reg;
  assign bus.data_out   = data_out_reg;
  assign bus.chan_out   = chan_out_reg;

`ifdef SCHED_STATS_EN
  logic [15:0] idle_slots_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_slots_reg <= '0;
    end else if (slot && !grant_found && (idle_slots_reg != 16'hFFFF)) begin
      idle_slots_reg <= idle_slots_reg + 16'd1;
    end
  end

  assign bus.idle_slots = idle_slots_reg;
`else
  assign bus.idle_slots = '0;
`endif

endmodule

// File: tb/tb_dsp_sample_scheduler.sv
// Directed self-checking bench for dsp_sample_scheduler; expected idle_slots
// depends on whether SCHED_STATS_EN is defined for the build.
module tb_dsp_sample_scheduler;
  localparam int width     = 12;
  localparam int channels  = 4;
  localparam int div_width = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dsp_sample_scheduler_if #(.width(width), .channels(channels), .div_width(div_width)) sif ();

  dsp_sample_scheduler #(.width(width), .channels(channels), .div_width(div_width)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_idle4, exp_idle5;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [11:0] val);
    sif.data_in[ch*width +: width] = val;
  endtask

  task automatic expect_quiet(input string tag, input int n, input logic [11:0] held);
    for (int i = 0; i < n; i++) begin
      tick();
      check_val($sformatf("%s_sf%0d", tag, i), {31'd0, sif.sampl_freq}, 32'd0);
      check_val($sformatf("%s_ack%0d", tag, i), {28'd0, sif.ack}, 32'd0);
      check_val($sformatf("%s_hold%0d", tag, i), {20'd0, sif.data_out}, {20'd0, held});
    end
  endtask

  task automatic expect_grant(input string tag, input int ch, input logic [11:0] d);
    tick();
    check_val({tag, "_sf"}, {31'd0, sif.sampl_freq}, 32'd1);
    check_val({tag, "_ack"}, {28'd0, sif.ack}, 32'd1 << ch);
    check_val({tag, "_chan"}, {30'd0, sif.chan_out}, 32'(ch));
    check_val({tag, "_data"}, {20'd0, sif.data_out}, {20'd0, d});
    $display("grant %s: chan %0d data 0x%03h ack %b", tag, sif.chan_out, sif.data_out, sif.ack);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_ack"}, {28'd0, sif.ack}, 32'd0);
    check_val({tag, "_sf"}, {31'd0, sif.sampl_freq}, 32'd0);
    check_val({tag, "_data"}, {20'd0, sif.data_out}, 32'd0);
    check_val({tag, "_chan"}, {30'd0, sif.chan_out}, 32'd0);
    check_val({tag, "_idle"}, {16'd0, sif.idle_slots}, 32'd0);
  endtask

  initial begin
`ifdef SCHED_STATS_EN
    exp_idle4 = 32'd4;
    exp_idle5 = 32'd5;
`else
    exp_idle4 = 32'd0;
    exp_idle5 = 32'd0;
`endif
    reset       = 1'b1;
    sif.enable  = 1'b0;
    sif.div     = '0;
    sif.req     = '0;
    sif.data_in = '0;
    tick();
    tick();
    check_cleared("reset");

    // Round robin, div=3: first grant 5 cycles after enable, then every 4.
    for (int k = 0; k < channels; k++) set_data(k, 12'h100 + 12'(k));
    reset      = 1'b0;
    sif.enable = 1'b1;
    sif.div    = 8'd3;
    sif.req    = 4'b1111;
    expect_quiet("rr_lat", 4, 12'h000);
    expect_grant("rr0", 0, 12'h100);
    for (int k = 1; k <= 5; k++) begin
      expect_quiet($sformatf("rr_gap%0d", k), 3, 12'h100 + 12'((k - 1) % 4));
      expect_grant($sformatf("rr%0d", k), k % 4, 12'h100 + 12'(k % 4));
    end

    // Asynchronous reset in the middle of a grant, ptr was 2.
    reset = 1'b1;
    #1;
    check_cleared("rst_async");
    tick();
    tick();
    check_cleared("rst_hold");
    reset = 1'b0;
    expect_quiet("rst_rel", 4, 12'h000);
    expect_grant("rst_first", 0, 12'h100);

    // Enable dropped one cycle before a slot: slot is lost.
    expect_quiet("ab_pre", 2, 12'h100);
    sif.enable = 1'b0;
    expect_quiet("ab_drop", 3, 12'h100);
    sif.enable = 1'b1;
    expect_quiet("ab_reen", 4, 12'h100);
    expect_grant("ab_first", 1, 12'h101);

    // Enable dropped in the slot cycle itself: grant still issued.
    expect_quiet("ef_pre", 3, 12'h101);
    sif.enable = 1'b0;
    expect_grant("ef_slot", 2, 12'h102);
    expect_quiet("ef_post", 3, 12'h102);

    // Sparse request on channel 2 only, div=9 (ptr wraps 3->0->2).
    set_data(2, 12'h8F3);
    sif.req    = 4'b0100;
    sif.div    = 8'd9;
    sif.enable = 1'b1;
    expect_quiet("sp_lat", 10, 12'h102);
    expect_grant("sp0", 2, 12'h8F3);
    expect_quiet("sp_gap1", 9, 12'h8F3);
    expect_grant("sp1", 2, 12'h8F3);
    expect_quiet("sp_gap2", 9, 12'h8F3);
    expect_grant("sp2", 2, 12'h8F3);
    sif.enable = 1'b0;
    expect_quiet("sp_off", 2, 12'h8F3);

    // div=0 behaves like div=1: slot every 2 cycles; ptr is 3.
    set_data(2, 12'h102);
    sif.req    = 4'b1111;
    sif.div    = 8'd0;
    sif.enable = 1'b1;
    expect_quiet("d0_lat", 2, 12'h8F3);
    expect_grant("d0_a", 3, 12'h103);
    expect_quiet("d0_g1", 1, 12'h103);
    expect_grant("d0_b", 0, 12'h100);
    expect_quiet("d0_g2", 1, 12'h100);
    expect_grant("d0_c", 1, 12'h101);
    expect_quiet("d0_g3", 1, 12'h101);
    expect_grant("d0_d", 2, 12'h102);
    sif.enable = 1'b0;
    expect_quiet("d0_off", 2, 12'h102);

    // div lowered 20 -> 2 while cnt=10: immediate slot, then period 3.
    sif.req    = 4'b0001;
    sif.div    = 8'd20;
    sif.enable = 1'b1;
    expect_quiet("dc_run", 11, 12'h102);
    sif.div = 8'd2;
    expect_grant("dc_a", 0, 12'h100);
    expect_quiet("dc_g1", 2, 12'h100);
    expect_grant("dc_b", 0, 12'h100);
    expect_quiet("dc_g2", 2, 12'h100);
    expect_grant("dc_c", 0, 12'h100);

    // Idle slots from a fresh reset: 5 slots with no request.
    sif.enable = 1'b0;
    reset      = 1'b1;
    tick();
    reset      = 1'b0;
    sif.req    = '0;
    sif.div    = 8'd3;
    sif.enable = 1'b1;
    expect_quiet("idle", 20, 12'h000);
    check_val("idle_slots4", {16'd0, sif.idle_slots}, exp_idle4);
    expect_quiet("idle_last", 1, 12'h000);
    check_val("idle_slots5", {16'd0, sif.idle_slots}, exp_idle5);
    sif.enable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
